car_sensor_driver: RTL and testbench

Stimulus-side counterpart to `parking_lot_occupancy`: converts single-cycle "car enters" / "car exits" requests into the two-sensor blocking sequence that the occupancy detector decodes. It drives the outer and inner sensor lines, holding each phase for a programmable number of cycles. It keeps a shadow occupancy count so it never emits an impossible event. It sits beside the occupancy block on the board top, or drives it directly in the bench, in place of the manual GPIO switches.

---
 rtl/parking_pkg.sv | 38 +++
 rtl/phase_timer.sv | 26 ++
 rtl/car_sensor_driver.sv | 168 ++++++++++++++++
 tb/tb_car_sensor_driver.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared constants for the parking-lot sensor blocks: FSM state encoding,
// direction codes and the {outer, inner} sensor phase patterns.
package parking_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_P1   = 3'd1,
      ST_P2   = 3'd2,
      ST_P3   = 3'd3,
      ST_BACK = 3'd4,
      ST_GAP  = 3'd5
   } state_t;

   localparam logic DIR_ENTER = 1'b1;
   localparam logic DIR_EXIT  = 1'b0;

   localparam logic [1:0] SENSORS_CLEAR = 2'b00;
   localparam logic [1:0] ENTER_P1      = 2'b10;
   localparam logic [1:0] ENTER_P2      = 2'b11;
   localparam logic [1:0] ENTER_P3      = 2'b01;
   localparam logic [1:0] EXIT_P1       = 2'b01;
   localparam logic [1:0] EXIT_P2       = 2'b11;
   localparam logic [1:0] EXIT_P3       = 2'b10;

   // BACK re-presents the first phase of the sequence as the car backs out.
   function automatic logic [1:0] phase_sensors(input state_t st, input logic dir);
      logic [1:0] s;
      s = SENSORS_CLEAR;
      case (st)
         ST_P1, ST_BACK: s = (dir == DIR_ENTER) ? ENTER_P1 : EXIT_P1;
         ST_P2:          s = (dir == DIR_ENTER) ? ENTER_P2 : EXIT_P2;
         ST_P3:          s = (dir == DIR_ENTER) ? ENTER_P3 : EXIT_P3;
         default:        s = SENSORS_CLEAR;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; expired is high once the loaded value has counted to zero.
module phase_timer #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/car_sensor_driver.sv
// Turns single-cycle enter/exit requests into the two-sensor blocking sequence.
// Optional mid-sequence back-out support is built when CAR_SENSOR_ABORT_EN is defined.
module car_sensor_driver
   import parking_pkg::*;
#(
   parameter int PHASE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2,
   parameter int MAX_CARS     = 25,
   parameter int CNT_W        = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_dir,
   output logic             req_ready,
   input  logic             abort,
   output logic             sensor_outer,
   output logic             sensor_inner,
   output logic             done,
   output logic             reject,
   output logic             aborted,
   output logic [CNT_W-1:0] occupancy
);

   localparam int MAX_HOLD = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
   localparam int TIMER_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [TIMER_W-1:0] PHASE_LOAD = TIMER_W'(PHASE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]   FULL       = CNT_W'(MAX_CARS);

   state_t             state;
   state_t             next_state;
   logic               dir;
   logic               dir_next;
   logic               timer_load;
   logic [TIMER_W-1:0] timer_value;
   logic               timer_expired;
   logic               refuse;
   logic               accept;
   logic               finish_done;
   logic               finish_abort;
   logic [1:0]         sensors_next;

   phase_timer #(.WIDTH(TIMER_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .expired    (timer_expired)
   );

   // Every phase change reloads the shared timer with the hold time of the phase being entered.
   always_comb begin
      next_state   = state;
      timer_load   = 1'b0;
      timer_value  = PHASE_LOAD;
      refuse       = 1'b0;
      accept       = 1'b0;
      finish_done  = 1'b0;
      finish_abort = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if ((req_dir == DIR_ENTER && occupancy == FULL) ||
                   (req_dir == DIR_EXIT && occupancy == '0)) begin
                  refuse = 1'b1;
               end else begin
                  accept     = 1'b1;
                  next_state = ST_P1;
                  timer_load = 1'b1;
               end
            end
         end
         ST_P1: begin
`ifdef CAR_SENSOR_ABORT_EN
            if (abort) begin
               next_state   = ST_GAP;
               timer_load   = 1'b1;
               timer_value  = GAP_LOAD;
               finish_abort = 1'b1;
            end else
`endif
            if (timer_expired) begin
               next_state = ST_P2;
               timer_load = 1'b1;
            end
         end
         ST_P2: begin
`ifdef CAR_SENSOR_ABORT_EN
            if (abort) begin
               next_state = ST_BACK;
               timer_load = 1'b1;
            end else
`endif
            if (timer_expired) begin
               next_state = ST_P3;
               timer_load = 1'b1;
            end
         end
         ST_P3: begin
            if (timer_expired) begin
               next_state  = ST_GAP;
               timer_load  = 1'b1;
               timer_value = GAP_LOAD;
               finish_done = 1'b1;
            end
         end
`ifdef CAR_SENSOR_ABORT_EN
         ST_BACK: begin
            if (timer_expired) begin
               next_state   = ST_GAP;
               timer_load   = 1'b1;
               timer_value  = GAP_LOAD;
               finish_abort = 1'b1;
            end
         end
`endif
         ST_GAP: begin
            if (timer_expired) begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign dir_next     = accept ? req_dir : dir;
   assign sensors_next = phase_sensors(next_state, dir_next);
   assign req_ready    = (state == ST_IDLE);

   // Sensors are registered from the next state so they change cleanly on the clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         dir          <= DIR_EXIT;
         sensor_outer <= 1'b0;
         sensor_inner <= 1'b0;
         done         <= 1'b0;
         reject       <= 1'b0;
         occupancy    <= '0;
      end else begin
         state        <= next_state;
         dir          <= dir_next;
         sensor_outer <= sensors_next[1];
         sensor_inner <= sensors_next[0];
         done         <= finish_done;
         reject       <= refuse;
         if (finish_done) begin
            occupancy <= (dir == DIR_ENTER) ? occupancy + CNT_W'(1) : occupancy - CNT_W'(1);
         end
      end
   end

`ifdef CAR_SENSOR_ABORT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aborted <= 1'b0;
      end else begin
         aborted <= finish_abort;
      end
   end
`else
   logic unused_abort;
   assign unused_abort = abort ^ finish_abort;
   assign aborted      = 1'b0;
`endif

endmodule

// File: tb/tb_car_sensor_driver.sv
// Scoreboard bench for car_sensor_driver: randomized requests are predicted by a
// cycle-indexed model of the sensor waveform and a queue of expected pulses.
module tb_car_sensor_driver;
   import parking_pkg::*;

   localparam int N   = 4;
   localparam int GAP = 2;
   localparam int MAX = 25;
   localparam int CW  = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_dir = 1'b0;
   logic          abort = 1'b0;
   logic          req_ready;
   logic          sensor_outer;
   logic          sensor_inner;
   logic          done;
   logic          reject;
   logic          aborted;
   logic [CW-1:0] occupancy;

   car_sensor_driver #(
      .PHASE_CYCLES (N),
      .GAP_CYCLES   (GAP),
      .MAX_CARS     (MAX),
      .CNT_W        (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_dir      (req_dir),
      .req_ready    (req_ready),
      .abort        (abort),
      .sensor_outer (sensor_outer),
      .sensor_inner (sensor_inner),
      .done         (done),
      .reject       (reject),
      .aborted      (aborted),
      .occupancy    (occupancy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int cyc;
      int occ;
   } ev_t;

   int         tests = 0;
   int         fails = 0;
   bit         chk_en = 1'b0;
   int         busy_until = 0;
   int         model_occ = 0;
   int         last_accept = 0;
   logic [1:0] exp_sens [int];
   ev_t        ev_q [$];
   logic [1:0] mon_exp;
   ev_t        mon_ev;

   // kind 1 = done, 2 = reject, 3 = aborted, as the {done, reject, aborted} bit pattern
   function automatic int kind_bits(input int kind);
      return (kind == 1) ? 4 : (kind == 2) ? 2 : 1;
   endfunction

   function automatic logic [1:0] pattern(input logic d, input int phase);
      if (d == DIR_ENTER) return (phase == 1) ? 2'b10 : (phase == 2) ? 2'b11 : 2'b01;
      return (phase == 1) ? 2'b01 : (phase == 2) ? 2'b11 : 2'b10;
   endfunction

   task automatic check_output(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: per-cycle sensor/ready comparison plus in-order pulse scoreboard.
   always @(negedge clk) begin
      if (chk_en) begin
         mon_exp = exp_sens.exists(cyc) ? exp_sens[cyc] : 2'b00;
         check_output("sensors", {sensor_outer, sensor_inner}, mon_exp);
         check_output("req_ready", req_ready, (cyc >= busy_until) ? 1 : 0);
         while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
            tests++;
            fails++;
            $display("[TB] FAIL missing pulse: kind %0d never seen, expected at cycle %0d", ev_q[0].kind, ev_q[0].cyc);
            void'(ev_q.pop_front());
         end
         if (done || reject || aborted) begin
            if (ev_q.size() == 0 || ev_q[0].cyc != cyc) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected pulse: got {done,reject,aborted}=%b, expected none (cycle %0d)",
                        {done, reject, aborted}, cyc);
            end else begin
               mon_ev = ev_q.pop_front();
               check_output("pulse kind", {29'd0, done, reject, aborted}, kind_bits(mon_ev.kind));
               check_output("occupancy at pulse", occupancy, mon_ev.occ);
            end
         end
      end
   end

   // Issue one request; hold keeps req_valid high while the driver is still busy.
   task automatic apply_stimulus(input logic d, input int abort_k, input bit hold);
      int a;
      int ab;
      bit refused;
      @(negedge clk);
      if (hold) begin
         req_valid = 1'b1;
         req_dir   = d;
      end else begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      while (cyc < busy_until) @(negedge clk);
      req_valid = 1'b1;
      req_dir   = d;
      @(posedge clk);
      #1;
      a           = cyc;
      last_accept = a;
      req_valid   = 1'b0;
      refused     = (d == DIR_ENTER && model_occ == MAX) || (d == DIR_EXIT && model_occ == 0);
      if (refused) begin
         ev_q.push_back('{2, a, model_occ});
         busy_until = a;
      end else begin
         ab = 0;
`ifdef CAR_SENSOR_ABORT_EN
         if (abort_k >= 1 && abort_k <= N) ab = 1;
         else if (abort_k > N && abort_k <= 2 * N) ab = 2;
`endif
         if (ab == 0) begin
            for (int p = 1; p <= 3 * N; p++) exp_sens[a + p - 1] = pattern(d, (p - 1) / N + 1);
            model_occ += (d == DIR_ENTER) ? 1 : -1;
            ev_q.push_back('{1, a + 3 * N, model_occ});
            busy_until = a + 3 * N + GAP;
         end else if (ab == 1) begin
            for (int p = 1; p <= abort_k; p++) exp_sens[a + p - 1] = pattern(d, 1);
            ev_q.push_back('{3, a + abort_k, model_occ});
            busy_until = a + abort_k + GAP;
         end else begin
            for (int p = 1; p <= abort_k; p++) exp_sens[a + p - 1] = pattern(d, (p - 1) / N + 1);
            for (int p = abort_k + 1; p <= abort_k + N; p++) exp_sens[a + p - 1] = pattern(d, 1);
            ev_q.push_back('{3, a + abort_k + N, model_occ});
            busy_until = a + abort_k + N + GAP;
         end
      end
      if (abort_k > 0 && !refused) begin
         do @(negedge clk); while (cyc < a + abort_k - 1);
         abort = 1'b1;
         @(posedge clk);
         #1;
         abort = 1'b0;
      end
   endtask

   task automatic wait_idle();
      while (cyc < busy_until + 1) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_output("reset sensors", {sensor_outer, sensor_inner}, 0);
      check_output("reset req_ready", req_ready, 1);
      check_output("reset pulses", {done, reject, aborted}, 0);
      check_output("reset occupancy", occupancy, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      busy_until = cyc;
      chk_en     = 1'b1;

      apply_stimulus(DIR_EXIT, 0, 1'b0);
      apply_stimulus(DIR_ENTER, 0, 1'b0);
      wait_idle();
      check_output("occupancy after first enter", occupancy, 1);

      // Reset in cycle 6 of an enter sequence.
      apply_stimulus(DIR_ENTER, 0, 1'b0);
      while (cyc < last_accept + 5) begin
         @(posedge clk);
         #1;
      end
      chk_en = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_output("sensors during reset", {sensor_outer, sensor_inner}, 0);
      check_output("occupancy during reset", occupancy, 0);
      check_output("done during reset", done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_sens.delete();
      ev_q.delete();
      model_occ = 0;
      @(posedge clk);
      #1;
      busy_until = cyc;
      check_output("idle after reset", req_ready, 1);
      chk_en = 1'b1;

      apply_stimulus(DIR_ENTER, 0, 1'b1);
      apply_stimulus(DIR_ENTER, 0, 1'b1);
      apply_stimulus(DIR_ENTER, 0, 1'b1);
      apply_stimulus(DIR_EXIT, 0, 1'b1);
      wait_idle();
      check_output("occupancy after 3 enters 1 exit", occupancy, 2);

`ifdef CAR_SENSOR_ABORT_EN
      apply_stimulus(DIR_ENTER, 6, 1'b0);
      wait_idle();
      check_output("occupancy after abort in P2", occupancy, 2);
      apply_stimulus(DIR_ENTER, 2 * N + 2, 1'b0);
      wait_idle();
      check_output("occupancy after abort in P3", occupancy, 3);
`endif

      while (model_occ < MAX) apply_stimulus(DIR_ENTER, 0, 1'b1);
      apply_stimulus(DIR_ENTER, 0, 1'b0);
      wait_idle();
      check_output("occupancy at full lot", occupancy, MAX);

      for (int i = 0; i < 40; i++) begin
         apply_stimulus(($urandom_range(0, 99) < 45) ? DIR_ENTER : DIR_EXIT,
                        ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3 * N)) : 0,
                        1'($urandom_range(0, 1)));
      end

      wait_idle();
      repeat (2) @(negedge clk);
      check_output("scoreboard drained", ev_q.size(), 0);
      check_output("final occupancy", occupancy, model_occ);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
